// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode 7-segment driver with a frame-synchronous double buffer.
// an/seg are registered one cycle behind the scan index; the input side has no backpressure.
module seg7_scan_driver #(
  parameter int DIV      = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        neg_in,
  input  logic        err_in,
  input  logic        load,
  output logic        pending,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef struct packed {
    logic [15:0] val;
    logic        neg;
    logic        err;
  } disp_t;

  cnt_t        cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  disp_t       shadow_q, shadow_d;
  disp_t       active_q, active_d;
  logic        pend_q, pend_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        slot_end;
  logic        frame_end;
  disp_t       incoming;

  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic        hi3_zero, hi2_zero, hi1_zero;
  logic        blank;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Scan timebase
  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 2'd3);
    cnt_d     = slot_end ? '0 : cnt_q + cnt_t'(1);
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
  end

  // Double buffer: the shadow collects loads, the active copy only changes at frame end.
  always_comb begin
    incoming.val = value_in;
    incoming.neg = neg_in;
    incoming.err = err_in;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pend_d       = pend_q;
    if (load) begin
      shadow_d = incoming;
    end
    if (frame_end) begin
      if (load) begin
        active_d = incoming;
      end else if (pend_q) begin
        active_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end
  end

  // Digit content for the slot currently selected by idx_q
  always_comb begin
    case (idx_q)
      2'd0:    nib = active_q.val[3:0];
      2'd1:    nib = active_q.val[7:4];
      2'd2:    nib = active_q.val[11:8];
      default: nib = active_q.val[15:12];
    endcase

    // With a minus sign in d3, the top nibble no longer takes part in zero suppression.
    hi3_zero = !active_q.neg && (active_q.val[15:12] == 4'h0);
    hi2_zero = (active_q.neg || (active_q.val[15:12] == 4'h0)) && (active_q.val[11:8] == 4'h0);
    hi1_zero = hi2_zero && (active_q.val[7:4] == 4'h0);

    glyph = hex_glyph(nib);
    blank = 1'b0;
    if (active_q.err) begin
      case (idx_q)
        2'd3:    blank = 1'b1;
        2'd2:    glyph = SEG_E;
        default: glyph = SEG_R;
      endcase
    end else begin
      case (idx_q)
        2'd3: begin
          if (active_q.neg) begin
            glyph = SEG_MINUS;
          end else begin
            blank = BLANK_LZ && hi3_zero;
          end
        end
        2'd2:    blank = BLANK_LZ && hi2_zero;
        2'd1:    blank = BLANK_LZ && hi1_zero;
        default: blank = 1'b0;
      endcase
    end

    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : glyph;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign pending = pend_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (zero blanking on/off) checked against a
// frame/slot arithmetic reference model, a table of display images, and reset/load corner sequences.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic        neg_in = 1'b0;
  logic        err_in = 1'b0;
  logic        load = 1'b0;

  logic        pend0, pend1, dp0, dp1;
  logic [6:0]  seg0, seg1;
  logic [3:0]  an0, an1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  seg7_scan_driver #(.DIV(DIV), .BLANK_LZ(1'b1)) dut0 (
    .clk(clk), .rst(rst), .value_in(value_in), .neg_in(neg_in), .err_in(err_in),
    .load(load), .pending(pend0), .seg(seg0), .an(an0), .dp(dp0)
  );

  seg7_scan_driver #(.DIV(DIV), .BLANK_LZ(1'b0)) dut1 (
    .clk(clk), .rst(rst), .value_in(value_in), .neg_in(neg_in), .err_in(err_in),
    .load(load), .pending(pend1), .seg(seg1), .an(an1), .dp(dp1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Glyph index: 0..15 hex, 16 '-', 17 'r', -1 blank.
  logic [6:0] glyph_tab [0:17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                                   7'h3F, 7'h2F};

  function automatic void render(input int slot, input logic [15:0] v, input logic n,
                                 input logic e, input logic lz,
                                 output logic [3:0] an_o, output logic [6:0] seg_o);
    int g[4];
    int top;
    if (e) begin
      g[3] = -1; g[2] = 14; g[1] = 17; g[0] = 17;
    end else begin
      for (int k = 0; k < 4; k++) g[k] = int'(v[4*k +: 4]);
      if (n) g[3] = 16;
      if (lz) begin
        top = n ? 2 : 3;
        for (int k = top; k >= 1; k--) begin
          if (g[k] == 0) g[k] = -1;
          else break;
        end
      end
    end
    if (g[slot] < 0) begin
      an_o  = 4'b1111;
      seg_o = 7'h7F;
    end else begin
      an_o  = ~(4'(4'b0001 << slot));
      seg_o = glyph_tab[g[slot]];
    end
  endfunction

  // Reference model: time since reset determines slot and frame position.
  int          m_t;
  logic [15:0] m_av, m_sv;
  logic        m_aneg, m_aerr, m_sneg, m_serr, m_pend;
  logic [3:0]  e_an0, e_an1;
  logic [6:0]  e_seg0, e_seg1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_av = '0; m_aneg = 0; m_aerr = 0;
      m_sv = '0; m_sneg = 0; m_serr = 0; m_pend = 0;
      e_an0 = 4'hF; e_an1 = 4'hF; e_seg0 = 7'h7F; e_seg1 = 7'h7F;
    end else begin
      render((m_t / DIV) % 4, m_av, m_aneg, m_aerr, 1'b1, e_an0, e_seg0);
      render((m_t / DIV) % 4, m_av, m_aneg, m_aerr, 1'b0, e_an1, e_seg1);
      if (m_t % FRAME == FRAME - 1) begin
        if (load) begin
          m_av = value_in; m_aneg = neg_in; m_aerr = err_in;
        end else if (m_pend) begin
          m_av = m_sv; m_aneg = m_sneg; m_aerr = m_serr;
        end
        m_pend = 0;
      end else if (load) begin
        m_sv = value_in; m_sneg = neg_in; m_serr = err_in; m_pend = 1;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_an0", 32'(an0), 32'(e_an0));
      chk("model_seg0", 32'(seg0), 32'(e_seg0));
      chk("model_an1", 32'(an1), 32'(e_an1));
      chk("model_seg1", 32'(seg1), 32'(e_seg1));
      chk("model_pend0", 32'(pend0), 32'(m_pend));
      chk("model_pend1", 32'(pend1), 32'(m_pend));
      chk("dp", 32'({dp1, dp0}), 32'(2'b11));
    end
  end

  typedef struct {
    logic [15:0]      v;
    logic             n;
    logic             e;
    logic [3:0][6:0]  lz;
    logic [3:0][6:0]  nl;
  } vec_t;

  vec_t vecs[9];

  task automatic do_load(input logic [15:0] v, input logic n, input logic e);
    value_in = v; neg_in = n; err_in = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic align(input int ph);
    int g = 0;
    while ((m_t % FRAME) != ph && g < 4 * FRAME) begin
      @(negedge clk);
      g++;
    end
    if (g >= 4 * FRAME) chk("align_timeout", 32'(g), 32'(0));
  endtask

  task automatic wait_commit();
    int g = 0;
    while (m_pend && g < 4 * FRAME) begin
      @(negedge clk);
      g++;
    end
    if (g >= 4 * FRAME) chk("commit_timeout", 32'(g), 32'(0));
  endtask

  task automatic check_frame(input string nm, input logic [3:0][6:0] lz, input logic [3:0][6:0] nl);
    logic [3:0] ea;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < DIV; j++) begin
        @(negedge clk);
        chk({nm, "_seg_lz"}, 32'(seg0), 32'(lz[k]));
        ea = (lz[k] == 7'h7F) ? 4'hF : ~(4'(4'b0001 << k));
        chk({nm, "_an_lz"}, 32'(an0), 32'(ea));
        chk({nm, "_seg_nl"}, 32'(seg1), 32'(nl[k]));
        ea = (nl[k] == 7'h7F) ? 4'hF : ~(4'(4'b0001 << k));
        chk({nm, "_an_nl"}, 32'(an1), 32'(ea));
      end
    end
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 1'b0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vecs[1] = '{16'h0050, 1'b0, 1'b0, {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h40, 7'h40, 7'h12, 7'h40}};
    vecs[2] = '{16'h9007, 1'b1, 1'b0, {7'h3F, 7'h7F, 7'h7F, 7'h78}, {7'h3F, 7'h40, 7'h40, 7'h78}};
    vecs[3] = '{16'h1234, 1'b1, 1'b1, {7'h7F, 7'h06, 7'h2F, 7'h2F}, {7'h7F, 7'h06, 7'h2F, 7'h2F}};
    vecs[4] = '{16'h0000, 1'b0, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{16'hF00D, 1'b0, 1'b0, {7'h0E, 7'h40, 7'h40, 7'h21}, {7'h0E, 7'h40, 7'h40, 7'h21}};
    vecs[6] = '{16'h0000, 1'b1, 1'b0, {7'h3F, 7'h7F, 7'h7F, 7'h40}, {7'h3F, 7'h40, 7'h40, 7'h40}};
    vecs[7] = '{16'h0C30, 1'b1, 1'b0, {7'h3F, 7'h46, 7'h30, 7'h40}, {7'h3F, 7'h46, 7'h30, 7'h40}};
    vecs[8] = '{16'h0B06, 1'b0, 1'b0, {7'h7F, 7'h03, 7'h40, 7'h02}, {7'h40, 7'h03, 7'h40, 7'h02}};

    // Reset image and first slots after release
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an0), 32'(4'hF));
    chk("rst_seg", 32'(seg0), 32'(7'h7F));
    chk("rst_pend", 32'(pend0), 32'(0));
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rel_slot0_an", 32'(an0), 32'(4'b1110));
    chk("rel_slot0_seg", 32'(seg0), 32'(7'h40));
    repeat (DIV) @(negedge clk);
    chk("rel_slot1_an_lz", 32'(an0), 32'(4'hF));
    chk("rel_slot1_an_nl", 32'(an1), 32'(4'b1101));

    // Table of display images
    for (int i = 0; i < 9; i++) begin
      align(3);
      do_load(vecs[i].v, vecs[i].n, vecs[i].e);
      chk("vec_pending", 32'(pend0), 32'(1));
      wait_commit();
      check_frame($sformatf("vec%0d", i), vecs[i].lz, vecs[i].nl);
    end

    // Last load in a frame wins
    align(1);
    do_load(16'h1111, 1'b0, 1'b0);
    do_load(16'h2222, 1'b0, 1'b0);
    wait_commit();
    check_frame("last_wins", {7'h24, 7'h24, 7'h24, 7'h24}, {7'h24, 7'h24, 7'h24, 7'h24});

    // Load on the frame-end cycle commits straight through
    align(FRAME - 1);
    do_load(16'h3333, 1'b0, 1'b0);
    chk("fe_load_pending", 32'(pend0), 32'(0));
    check_frame("fe_load", {7'h30, 7'h30, 7'h30, 7'h30}, {7'h30, 7'h30, 7'h30, 7'h30});

    // Async reset mid-scan discards a pending load
    align(3);
    do_load(16'h4321, 1'b0, 1'b0);
    chk("pre_rst_pending", 32'(pend0), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", 32'(an0), 32'(4'hF));
    chk("async_rst_seg", 32'(seg0), 32'(7'h7F));
    chk("async_rst_pend", 32'(pend0), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", 32'(an0), 32'(4'b1110));
    chk("post_rst_seg", 32'(seg0), 32'(7'h40));
    repeat (2 * FRAME) @(negedge clk);
    chk("post_rst_still_zero", 32'(m_av), 32'(0));

    // Random loads checked by the model
    for (int c = 0; c < 600; c++) begin
      value_in = 16'($urandom);
      neg_in   = ($urandom % 3) == 0;
      err_in   = ($urandom % 8) == 0;
      load     = ($urandom % 5) == 0;
      @(negedge clk);
    end
    load = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
